// File: rtl/if_stage_if.sv
// ----------------------------------------------------------------------------
// if_stage_if : instruction-memory fetch handshake between the IF stage and
//               the instruction memory.
//
//   imem_addr   fetch address, driven by the IF stage (master)
//   imem_rdata  instruction word for imem_addr, driven by memory (slave)
//   imem_ready  imem_rdata is valid this cycle, driven by memory (slave)
// ----------------------------------------------------------------------------
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface : if_stage_if

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage : instruction-fetch stage of a 5-stage MIPS pipeline.
//   Holds the PC, selects the next PC (sequential / branch / jump / stall),
//   fetches through the imem handshake and loads the IF/ID pipeline register.
//
// Ports
//   clk           pipeline clock, all state updates on the rising edge
//   reset         synchronous, active-high reset
//   PCWrite       1 = PC may update, 0 = hold PC (load-use stall)
//   IFIDWrite     1 = IF/ID may update, 0 = hold IF/ID
//   IFFlush       squash the instruction entering IF/ID this cycle
//   PCSrc         taken branch resolved in ID
//   BranchTarget  branch target address
//   Jump          jump resolved in ID (wins over PCSrc)
//   JumpTarget    jump target address
//   imem          fetch handshake (imem_addr out, imem_rdata/imem_ready in)
//   PC            current PC register
//   IFID_PC4      registered PC+4 of the instruction in ID
//   IFID_Instr    registered instruction in ID
//   IFID_Valid    1 = IFID_Instr is a real instruction, 0 = bubble
// ----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000   // sll $0,$0,0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                PCWrite,
  input  logic                IFIDWrite,
  input  logic                IFFlush,
  input  logic                PCSrc,
  input  logic [31:0]         BranchTarget,
  input  logic                Jump,
  input  logic [31:0]         JumpTarget,
  if_stage_if.master          imem,
  output logic [31:0]         PC,
  output logic [31:0]         IFID_PC4,
  output logic [31:0]         IFID_Instr,
  output logic                IFID_Valid
);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_pc4;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_squash;

  assign w_redirect = Jump | PCSrc;
  assign w_target   = Jump ? JumpTarget : BranchTarget;
  // 32-bit add wraps naturally: 32'hFFFF_FFFC + 4 = 0.
  assign w_pc_plus4 = r_pc + 32'd4;

  // A redirect only counts when the PC actually takes it; a stalled branch is
  // re-presented by ID after the stall, so its sequential fetch is not killed.
  // A word that is not ready is also turned into a bubble.
  assign w_squash = IFFlush | (PCWrite & w_redirect) | ~imem.imem_ready;

  assign imem.imem_addr = r_pc;
  assign PC             = r_pc;
  assign IFID_PC4       = r_ifid_pc4;
  assign IFID_Instr     = r_ifid_instr;
  assign IFID_Valid     = r_ifid_valid;

  // PC register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (PCWrite) begin
      if (w_redirect) begin
        r_pc <= w_target;          // abandoned fetch is dropped
      end else if (imem.imem_ready) begin
        r_pc <= w_pc_plus4;
      end
    end
  end

  // IF/ID pipeline register. Holding (IFIDWrite=0) takes precedence over flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifid_pc4   <= 32'd0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (IFIDWrite) begin
      r_ifid_pc4 <= w_pc_plus4;
      if (w_squash) begin
        r_ifid_instr <= NOP_INSTR;
        r_ifid_valid <= 1'b0;
      end else begin
        r_ifid_instr <= imem.imem_rdata;
        r_ifid_valid <= 1'b1;
      end
    end
  end

endmodule : if_stage

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage : self-checking bench for if_stage.
//   A driver applies one cycle of stimulus at each falling edge, advances a
//   reference model of the fetch stage and queues the state expected after
//   the next rising edge. A monitor pops that queue just after each rising
//   edge and compares it with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct {
    logic        rst;
    logic        pcw;
    logic        ifidw;
    logic        flush;
    logic        pcsrc;
    logic [31:0] bt;
    logic        jump;
    logic [31:0] jt;
    logic        ready;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, IFIDWrite, IFFlush, PCSrc, Jump;
  logic [31:0] BranchTarget, JumpTarget;
  logic [31:0] PC, IFID_PC4, IFID_Instr;
  logic        IFID_Valid;

  if_stage_if imem ();

  if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk          (clk),
    .reset        (reset),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .IFFlush      (IFFlush),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .imem         (imem.master),
    .PC           (PC),
    .IFID_PC4     (IFID_PC4),
    .IFID_Instr   (IFID_Instr),
    .IFID_Valid   (IFID_Valid)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  // Reference model state: what the fetch stage should hold right now.
  logic [31:0] m_pc;
  logic [31:0] m_pc4;
  logic [31:0] m_instr;
  logic        m_valid;
  logic [31:0] salt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: each word is its own address, optionally
  // scrambled so random runs can tell words apart from addresses.
  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return addr ^ salt;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.pcw = 1'b1; s.ifidw = 1'b1; s.flush = 1'b0;
    s.pcsrc = 1'b0; s.bt = 32'd0; s.jump = 1'b0; s.jt = 32'd0; s.ready = 1'b1;
    return s;
  endfunction

  // Drive one cycle and record the expected post-edge state.
  task automatic step(input stim_t s, input string tag);
    logic [31:0] word;
    logic        redirect_taken;
    logic [31:0] next_pc;
    exp_t        e;
    @(negedge clk);
    word         = word_of(m_pc);
    reset        = s.rst;
    PCWrite      = s.pcw;
    IFIDWrite    = s.ifidw;
    IFFlush      = s.flush;
    PCSrc        = s.pcsrc;
    BranchTarget = s.bt;
    Jump         = s.jump;
    JumpTarget   = s.jt;
    imem.imem_ready = s.ready;
    imem.imem_rdata = s.ready ? word : 32'hDEAD_BEEF;   // junk must be ignored

    if (s.rst) begin
      m_pc = RESET_PC; m_pc4 = 32'd0; m_instr = NOP_INSTR; m_valid = 1'b0;
    end else begin
      redirect_taken = s.pcw && (s.jump || s.pcsrc);
      if (!s.pcw)               next_pc = m_pc;
      else if (s.jump)          next_pc = s.jt;
      else if (s.pcsrc)         next_pc = s.bt;
      else if (!s.ready)        next_pc = m_pc;
      else                      next_pc = m_pc + 32'd4;
      if (s.ifidw) begin
        m_pc4 = m_pc + 32'd4;
        if (s.flush || redirect_taken || !s.ready) begin
          m_instr = NOP_INSTR; m_valid = 1'b0;
        end else begin
          m_instr = word; m_valid = 1'b1;
        end
      end
      m_pc = next_pc;
    end
    e.pc = m_pc; e.pc4 = m_pc4; e.instr = m_instr; e.valid = m_valid; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT against each queued expectation after its edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".PC"},        PC,             e.pc);
        check({e.tag, ".imem_addr"}, imem.imem_addr, e.pc);
        check({e.tag, ".IFID_PC4"},  IFID_PC4,       e.pc4);
        check({e.tag, ".IFID_Instr"},IFID_Instr,     e.instr);
        check({e.tag, ".IFID_Valid"},{31'd0, IFID_Valid}, {31'd0, e.valid});
      end
    end
  end

  // Advance sequentially until the model PC reaches addr (bounded).
  task automatic run_to(input logic [31:0] addr, input string tag);
    for (int i = 0; i < 64 && m_pc != addr; i++) step(idle(), tag);
    if (m_pc != addr) begin
      n_checks++; n_errors++;
      $display("FAIL run_to %s: model pc %h never reached %h", tag, m_pc, addr);
    end
  endtask

  initial begin
    stim_t s;
    salt = 32'd0;
    m_pc = 32'd0; m_pc4 = 32'd0; m_instr = 32'd0; m_valid = 1'b0;
    reset = 1'b1; PCWrite = 1'b1; IFIDWrite = 1'b1; IFFlush = 1'b0;
    PCSrc = 1'b0; Jump = 1'b0; BranchTarget = 32'd0; JumpTarget = 32'd0;
    imem.imem_ready = 1'b1; imem.imem_rdata = 32'd0;

    // Reset, then free run: PC 0,4,8,C with IF/ID trailing by one.
    s = idle(); s.rst = 1'b1;
    step(s, "reset"); step(s, "reset");
    for (int i = 0; i < 4; i++) step(idle(), "freerun");

    // Load-use stall at PC=0x10.
    run_to(32'h10, "to10");
    s = idle(); s.pcw = 1'b0; s.ifidw = 1'b0;
    step(s, "loaduse");
    step(idle(), "after_stall");

    // Taken branch at 0x20 -> 0x100, one bubble, then 0x100 in IF/ID.
    run_to(32'h20, "to20");
    s = idle(); s.pcsrc = 1'b1; s.bt = 32'h100;
    step(s, "branch");
    step(idle(), "br_target");
    step(idle(), "br_next");

    // Jump wins over branch; both ignored while PCWrite=0.
    s = idle(); s.jump = 1'b1; s.jt = 32'h400; s.pcsrc = 1'b1; s.bt = 32'h200;
    step(s, "jump_vs_br");
    s.pcw = 1'b0;
    step(s, "redir_stalled");
    // Flush ignored while IF/ID held.
    s = idle(); s.flush = 1'b1; s.ifidw = 1'b0;
    step(s, "flush_held");
    // Flush without redirect: PC advances, word squashed.
    s = idle(); s.flush = 1'b1;
    step(s, "flush_seq");
    // Split stall: PC holds, IF/ID loads the held-PC word.
    s = idle(); s.pcw = 1'b0;
    step(s, "split_stall");
    step(idle(), "split_after");

    // imem not ready for 3 cycles at 0x30.
    s = idle(); s.jump = 1'b1; s.jt = 32'h30;
    step(s, "jump30");
    s = idle(); s.ready = 1'b0;
    for (int i = 0; i < 3; i++) step(s, "not_ready");
    step(idle(), "ready_back");
    step(idle(), "ready_next");
    // Redirect while not ready still redirects.
    s = idle(); s.ready = 1'b0; s.pcsrc = 1'b1; s.bt = 32'h80;
    step(s, "br_not_ready");

    // Wrap at the top of the address space.
    s = idle(); s.jump = 1'b1; s.jt = 32'hFFFF_FFFC;
    step(s, "jump_top");
    step(idle(), "wrap");
    step(idle(), "wrap_next");

    // Reset during a stall with a pending redirect.
    s = idle(); s.rst = 1'b1; s.pcw = 1'b0; s.ifidw = 1'b0; s.jump = 1'b1; s.jt = 32'h44;
    step(s, "reset_stall");
    step(idle(), "post_reset");

    // Randomized traffic.
    salt = $urandom;
    for (int i = 0; i < 400; i++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 99) < 2);
      s.pcw   = ($urandom_range(0, 99) < 85);
      s.ifidw = ($urandom_range(0, 99) < 85);
      s.flush = ($urandom_range(0, 99) < 10);
      s.pcsrc = ($urandom_range(0, 99) < 15);
      s.jump  = ($urandom_range(0, 99) < 10);
      s.bt    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      s.jt    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      s.ready = ($urandom_range(0, 99) < 80);
      step(s, "random");
    end

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++; n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_if_stage
